// File: rtl/conv1d_cmd_sequencer.sv
// conv1d_cmd_sequencer: takes one job descriptor and a 32-bit data word stream,
// then drives the conv1d CFU command port. The sequence is: configuration,
// filter/input buffer writes, start, done polling, result readback.
module conv1d_cmd_sequencer #(
  parameter int KERNEL_LENGTH = 8,
  parameter int CNT_W         = 16,
  parameter int POLL_TIMEOUT  = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_load_filter,
  input  logic [CNT_W-1:0] job_filter_words,
  input  logic [31:0]      job_input_base,
  input  logic [CNT_W-1:0] job_input_words,
  input  logic [31:0]      job_input_depth,
  input  logic [31:0]      job_input_offset,
  input  logic [31:0]      job_start_x,
  input  logic [31:0]      job_bias,
  input  logic [31:0]      job_mult,
  input  logic [31:0]      job_shift,
  input  logic [31:0]      job_act_min,
  input  logic [31:0]      job_act_max,
  input  logic [31:0]      job_out_offset,
  input  logic [31:0]      data_word,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [31:0]      res_data,
  output logic             res_timeout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             cfu_en,
  output logic [6:0]       cfu_cmd,
  output logic [31:0]      cfu_inp0,
  output logic [31:0]      cfu_inp1,
  input  logic [31:0]      cfu_ret,
  output logic             busy
);
  localparam int PW = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_LDF, S_LDI, S_START, S_POLL, S_CHK, S_READ, S_CAP, S_OUT
  } state_e;

  typedef struct packed {
    logic             lf;
    logic [CNT_W-1:0] fw;
    logic [CNT_W-1:0] iw;
    logic [31:0]      base;
    logic [31:0]      depth;
    logic [31:0]      ring;
    logic [31:0]      off;
    logic [31:0]      sx;
    logic [31:0]      bias;
    logic [31:0]      mult;
    logic [31:0]      shift;
    logic [31:0]      amin;
    logic [31:0]      amax;
    logic [31:0]      oofs;
  } job_t;

  state_e           state_q, state_d;
  job_t             job_q, job_d;
  logic [3:0]       cfg_idx_q, cfg_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [PW-1:0]    poll_q, poll_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_timeout_q, res_timeout_d;
  logic             cfu_en_q, cfu_en_d;
  logic [6:0]       cfu_cmd_q, cfu_cmd_d;
  logic [31:0]      cfu_inp0_q, cfu_inp0_d;
  logic [31:0]      cfu_inp1_q, cfu_inp1_d;

  logic             fire;
  logic [31:0]      addr_inc, addr_wrap;
  logic [PW-1:0]    poll_inc;

  // Stream handshake: accept words only while the current load phase has words left.
  assign data_ready = ((state_q == S_LDF) && (cnt_q != job_q.fw)) ||
                      ((state_q == S_LDI) && (cnt_q != job_q.iw));
  assign fire       = data_valid & data_ready;
  assign addr_inc   = addr_q + 32'd4;
  assign addr_wrap  = (addr_inc >= job_q.ring) ? addr_inc - job_q.ring : addr_inc;
  assign poll_inc   = poll_q + PW'(1);

  // State and datapath registers; an async reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      job_q         <= '0;
      cfg_idx_q     <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      poll_q        <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      cfu_en_q      <= 1'b0;
      cfu_cmd_q     <= '0;
      cfu_inp0_q    <= '0;
      cfu_inp1_q    <= '0;
    end else begin
      state_q       <= state_d;
      job_q         <= job_d;
      cfg_idx_q     <= cfg_idx_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      poll_q        <= poll_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      cfu_en_q      <= cfu_en_d;
      cfu_cmd_q     <= cfu_cmd_d;
      cfu_inp0_q    <= cfu_inp0_d;
      cfu_inp1_q    <= cfu_inp1_d;
    end
  end

  // Next-state logic. Each load phase exits one cycle after its last word, so
  // the lagged data command never collides with the following START command.
  always_comb begin
    state_d       = state_q;
    job_d         = job_q;
    cfg_idx_d     = cfg_idx_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    poll_d        = poll_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      S_IDLE: if (job_valid) begin
        job_d.lf      = job_load_filter;
        job_d.fw      = job_filter_words;
        job_d.iw      = job_input_words;
        job_d.base    = job_input_base;
        job_d.depth   = job_input_depth;
        job_d.ring    = 32'(KERNEL_LENGTH) * job_input_depth;
        job_d.off     = job_input_offset;
        job_d.sx      = job_start_x;
        job_d.bias    = job_bias;
        job_d.mult    = job_mult;
        job_d.shift   = job_shift;
        job_d.amin    = job_act_min;
        job_d.amax    = job_act_max;
        job_d.oofs    = job_out_offset;
        res_data_d    = '0;
        res_timeout_d = 1'b0;
        cfg_idx_d     = '0;
        state_d       = S_CFG;
      end
      S_CFG: begin
        if (cfg_idx_q == 4'd9) begin
          cnt_d = '0;
          if (job_q.lf && (job_q.fw != '0)) begin
            addr_d  = '0;
            state_d = S_LDF;
          end else if (job_q.iw != '0) begin
            addr_d  = job_q.base;
            state_d = S_LDI;
          end else begin
            state_d = S_START;
          end
        end else begin
          cfg_idx_d = cfg_idx_q + 4'd1;
        end
      end
      S_LDF: begin
        if (cnt_q == job_q.fw) begin
          cnt_d   = '0;
          addr_d  = job_q.base;
          state_d = (job_q.iw != '0) ? S_LDI : S_START;
        end else if (fire) begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = addr_inc;
        end
      end
      S_LDI: begin
        if (cnt_q == job_q.iw) begin
          state_d = S_START;
        end else if (fire) begin
          cnt_d  = cnt_q + CNT_W'(1);
          addr_d = addr_wrap;
        end
      end
      S_START: begin
        poll_d  = '0;
        state_d = S_POLL;
      end
      S_POLL: state_d = S_CHK;
      S_CHK: begin
        if (cfu_ret[0]) begin
          state_d = S_READ;
        end else if (poll_inc == PW'(POLL_TIMEOUT)) begin
          res_timeout_d = 1'b1;
          res_data_d    = '0;
          state_d       = S_OUT;
        end else begin
          poll_d  = poll_inc;
          state_d = S_POLL;
        end
      end
      S_READ: state_d = S_CAP;
      S_CAP: begin
        res_data_d = cfu_ret;
        state_d    = S_OUT;
      end
      S_OUT: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command outputs: data writes come from the fire cycle; every other command is
  // keyed on the state being entered, so it is visible while that state is held.
  always_comb begin
    cfu_en_d   = 1'b0;
    cfu_cmd_d  = '0;
    cfu_inp0_d = '0;
    cfu_inp1_d = '0;
    if (fire) begin
      cfu_en_d   = 1'b1;
      cfu_cmd_d  = (state_q == S_LDF) ? 7'd2 : 7'd1;
      cfu_inp0_d = addr_q;
      cfu_inp1_d = data_word;
    end else begin
      case (state_d)
        S_CFG: begin
          cfu_en_d = 1'b1;
          case (cfg_idx_d)
            4'd0:    begin cfu_cmd_d = 7'd16; cfu_inp1_d = 32'd4;       end
            4'd1:    begin cfu_cmd_d = 7'd3;  cfu_inp1_d = job_q.off;   end
            4'd2:    begin cfu_cmd_d = 7'd5;  cfu_inp1_d = job_q.depth; end
            4'd3:    begin cfu_cmd_d = 7'd8;  cfu_inp1_d = job_q.sx;    end
            4'd4:    begin cfu_cmd_d = 7'd10; cfu_inp1_d = job_q.bias;  end
            4'd5:    begin cfu_cmd_d = 7'd11; cfu_inp1_d = job_q.mult;  end
            4'd6:    begin cfu_cmd_d = 7'd12; cfu_inp1_d = job_q.shift; end
            4'd7:    begin cfu_cmd_d = 7'd13; cfu_inp1_d = job_q.amin;  end
            4'd8:    begin cfu_cmd_d = 7'd14; cfu_inp1_d = job_q.amax;  end
            default: begin cfu_cmd_d = 7'd15; cfu_inp1_d = job_q.oofs;  end
          endcase
        end
        S_START: begin cfu_en_d = 1'b1; cfu_cmd_d = 7'd6; end
        S_POLL:  begin cfu_en_d = 1'b1; cfu_cmd_d = 7'd9; end
        S_READ:  begin cfu_en_d = 1'b1; cfu_cmd_d = 7'd7; end
        default: ;
      endcase
    end
  end

  assign job_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign res_valid   = (state_q == S_OUT);
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign cfu_en      = cfu_en_q;
  assign cfu_cmd     = cfu_cmd_q;
  assign cfu_inp0    = cfu_inp0_q;
  assign cfu_inp1    = cfu_inp1_q;
endmodule
